mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/arb_timer.sv | 30 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the memory arbiter: FSM state encoding,
// grant-bit meaning and parameter defaults.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2
  } arb_state_t;

  // Value held in the last-grant flop for each requester
  localparam logic GRANT_IF_BIT = 1'b0;
  localparam logic GRANT_DM_BIT = 1'b1;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and unified memory.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_ready;

  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic [WIDTH-1:0] dm_rdata;
  logic             dm_ready;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  logic             stall_fetch;
  logic             stall_mem;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_fetch, stall_mem
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_fetch, stall_mem
  );

endinterface

// File: rtl/arb_timer.sv
// Wait-cycle counter for the memory arbiter; only instantiated when
// MEM_ARB_TIMEOUT_EN is defined.
module arb_timer
  import mips_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  // expired fires on the edge that would take the count to TIMEOUT
  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_cnt <= 8'd0;
    end else if (run) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = run && (r_cnt == TC);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter onto one unified memory port.
// Optional timeout with sticky err output when MEM_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | no access in flight; arbitrate unless a ready pulse is going out
// GRANT_IF | fetch access on the memory port, waiting for mem_ack
// GRANT_DM | data access on the memory port, waiting for mem_ack
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be within 2..255");
  end

  arb_state_t       r_state;
  logic             r_last;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [WIDTH-1:0] r_if_rdata;
  logic [WIDTH-1:0] r_dm_rdata;
  logic             r_if_ready;
  logic             r_dm_ready;

  logic             w_pick_dm;
  logic             w_rdy_busy;
  logic             w_expired;
  logic             w_finish;

  always_comb begin
    w_pick_dm  = bus.dm_req && (!bus.if_req || (r_last == GRANT_IF_BIT));
    w_rdy_busy = r_if_ready || r_dm_ready;
    w_finish   = bus.mem_ack || w_expired;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_err;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (r_mem_req && !bus.mem_ack),
    .clr     (!r_mem_req),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_expired) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_last      <= GRANT_IF_BIT;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          // Skipping the ready cycle keeps a still-held request from a second grant
          if (!w_rdy_busy && (bus.if_req || bus.dm_req)) begin
            r_mem_req <= 1'b1;
            if (w_pick_dm) begin
              r_state     <= GRANT_DM;
              r_last      <= GRANT_DM_BIT;
              r_mem_addr  <= bus.dm_addr;
              r_mem_wdata <= bus.dm_wdata;
              r_mem_we    <= bus.dm_we;
            end else begin
              r_state     <= GRANT_IF;
              r_last      <= GRANT_IF_BIT;
              r_mem_addr  <= bus.if_addr;
              r_mem_wdata <= '0;
              r_mem_we    <= 1'b0;
            end
          end
        end
        GRANT_IF: begin
          if (w_finish) begin
            r_if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            r_if_ready <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_state    <= IDLE;
          end
        end
        GRANT_DM: begin
          if (w_finish) begin
            if (!r_mem_we) begin
              r_dm_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            end
            r_dm_ready <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.if_ready    = r_if_ready;
  assign bus.dm_rdata    = r_dm_rdata;
  assign bus.dm_ready    = r_dm_ready;
  assign bus.stall_fetch = bus.if_req && !r_if_ready;
  assign bus.stall_mem   = bus.dm_req && !r_dm_ready;

endmodule
